// File: rtl/pipe_skid_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and registered in_ready_o.
// Optional perf counters (stall/flush) are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_skid_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs depend only on registered state, so no ready path crosses stages.
    assign out_valid_o = (state_q != StEmpty);
    assign in_ready_o  = (state_q != StFull);
    assign count_o     = state_q;
    assign data_o      = main_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StEmpty;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else if (flush_i) begin
            state_q <= StEmpty;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_q  <= data_i;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_q <= data_i;
                    end else if (in_fire) begin
                        skid_q  <= data_i;
                        state_q <= StFull;
                    end else if (out_fire) begin
                        // main_q keeps the consumed value; out_valid_o qualifies it
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= StBusy;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Self-checking bench for pipe_skid_stage_reg: vector table, corner sequences and a
// randomized run against a queue-based model of the stage.
module tb_pipe_skid_stage_reg;

    localparam logic [31:0] FLUSH = 32'h0000_0013;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] data_o;
    logic [1:0]  count_o;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
`endif

    pipe_skid_stage_reg #(
        .WIDTH     (32),
        .FLUSH_VAL (FLUSH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .count_o     (count_o)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: the stage is a 2-deep FIFO; data_o shows the head, or the last
    // consumed item when empty (FLUSH after reset/flush).
    logic [31:0] mq[$];
    logic [31:0] mlast;
    logic [31:0] mstall;
    logic [15:0] mflush;

    function automatic void model_reset();
        mq.delete();
        mlast  = FLUSH;
        mstall = '0;
        mflush = '0;
    endfunction

    function automatic void model_edge();
        bit v;
        bit r;
        v = (mq.size() > 0);
        r = (mq.size() < 2);
        if (v && !out_ready_i && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
        if (flush_i) begin
            if (mflush != 16'hFFFF) mflush = mflush + 1;
            mq.delete();
            mlast = FLUSH;
        end else begin
            if (v && out_ready_i) mlast = mq.pop_front();
            if (in_valid_i && r) mq.push_back(data_i);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " count"}, 32'(count_o), 32'(mq.size()));
        chk({tag, " valid"}, 32'(out_valid_o), 32'(mq.size() > 0));
        chk({tag, " ready"}, 32'(in_ready_o), 32'(mq.size() < 2));
        chk({tag, " data"}, data_o, (mq.size() > 0) ? mq[0] : mlast);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk({tag, " stall_cnt"}, stall_cnt_o, mstall);
        chk({tag, " flush_cnt"}, 32'(flush_cnt_o), 32'(mflush));
`endif
    endtask

    // Drive one cycle's inputs, advance the model, and land 1 time unit after the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid_i  = iv;
        data_i      = d;
        out_ready_i = ordy;
        flush_i     = fl;
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic [1:0]  cnt;
        logic        vld;
        logic        rdy;
        logic [31:0] dout;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    initial begin
        // streaming
        vecs[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h4};
        // backpressure into the skid entry, then drain
        vecs[5]  = '{1'b1, 32'hA, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA};
        vecs[6]  = '{1'b1, 32'hB, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'hA};
        vecs[7]  = '{1'b1, 32'hD, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'hA};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hB};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'hB};
        // flush while full with a concurrent input
        vecs[10] = '{1'b1, 32'h5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h5};
        vecs[11] = '{1'b1, 32'h6, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h5};
        vecs[12] = '{1'b1, 32'hC, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, FLUSH};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, FLUSH};
        // flush while busy with both in_fire and out_fire
        vecs[14] = '{1'b1, 32'h7, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h7};
        vecs[15] = '{1'b1, 32'h8, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, FLUSH};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, FLUSH};

        rst_i       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        data_i      = '0;
        out_ready_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("reset count", 32'(count_o), 32'd0);
        chk("reset valid", 32'(out_valid_o), 32'd0);
        chk("reset ready", 32'(in_ready_o), 32'd1);
        chk("reset data", data_o, FLUSH);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk_model("idle");

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d count", i), 32'(count_o), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d valid", i), 32'(out_valid_o), 32'(vecs[i].vld));
            chk($sformatf("vec%0d ready", i), 32'(in_ready_o), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d data", i), data_o, vecs[i].dout);
        end

        // Asynchronous reset in the middle of a cycle while busy
        step(1'b1, 32'h55, 1'b0, 1'b0);
        chk("pre-reset count", 32'(count_o), 32'd1);
        #3;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("async count", 32'(count_o), 32'd0);
        chk("async valid", 32'(out_valid_o), 32'd0);
        chk("async ready", 32'(in_ready_o), 32'd1);
        chk("async data", data_o, FLUSH);
        #2;
        rst_i = 1'b1;
        step(1'b1, 32'h66, 1'b1, 1'b0);
        chk("post-reset valid", 32'(out_valid_o), 32'd1);
        chk("post-reset data", data_o, 32'h66);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post-reset drain", 32'(count_o), 32'd0);

`ifdef PIPE_STAGE_PERF_CNT_EN
        rst_i = 1'b0;
        model_reset();
        #2;
        rst_i = 1'b1;
        step(1'b1, 32'h1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("perf stall_cnt", stall_cnt_o, 32'd5);
        chk("perf flush_cnt", 32'(flush_cnt_o), 32'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0);
            chk_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage_reg.md
Name: pipe_skid_stage_reg

Overview:
Parametrised elastic pipeline-stage register. It is the successor to the fixed write-enable/flush stage register used between CPU pipeline stages.
- Replaces the global write-enable stall with a per-stage valid/ready handshake.
- Adds a 2-entry skid buffer, so that in_ready_o is registered and there is no combinational ready path across stages.
- Keeps a synchronous flush for branch/hazard squash.

Parameters:
WIDTH, 32, payload width in bits (>=1)
FLUSH_VAL, 0, WIDTH-bit value loaded into data_o on reset and flush (NOP encoding)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous squash, highest priority
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  stage can accept (registered)
data_i  input  WIDTH  upstream payload
out_valid_o  output  1  data_o valid
out_ready_i  input  1  downstream accepts
data_o  output  WIDTH  payload to next stage (main register)
count_o  output  2  occupancy 0..2

Behaviour:
- Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives data_o) and skid register.
- States: EMPTY (count 0), BUSY (count 1, main valid), FULL (count 2, main+skid valid).
- Outputs are pure functions of registered state:
  - out_valid_o = (state != EMPTY)
  - in_ready_o = (state != FULL)
  - count_o = state encoding 0/1/2
- Reset (rst_i=0, asynchronous, any time incl. mid-transfer): state=EMPTY, out_valid_o=0, in_ready_o=1, count_o=0, data_o=FLUSH_VAL, skid=FLUSH_VAL.
- flush_i=1 at a clock edge: same result as reset. Any in_fire in that cycle is dropped. Any out_fire in that cycle still counts as consumed by downstream; no re-send.
- Transitions (flush_i=0):
  - EMPTY: in_fire -> BUSY, main<=data_i; else stay.
  - BUSY, in_fire & out_fire -> BUSY, main<=data_i.
  - BUSY, in_fire & !out_fire -> FULL, skid<=data_i, main unchanged.
  - BUSY, !in_fire & out_fire -> EMPTY, main retains value.
  - BUSY, neither -> hold.
  - FULL: in_ready_o=0, so no in_fire. out_fire -> BUSY, main<=skid. Else hold.
- Latency: 1 cycle data_i -> data_o when downstream is ready.
- Throughput: 1 item/cycle sustained.
- Ordering: strict FIFO; no duplication, no loss except by flush.
- Stability: while out_valid_o=1 and out_ready_i=0, data_o and out_valid_o stay constant.
- When EMPTY, data_o holds the last value (FLUSH_VAL after reset/flush); consumers qualify it with out_valid_o.
- in_valid_i may drop without a fire; data_i is sampled only on in_fire.

Optional Feature:
Macro PIPE_STAGE_PERF_CNT_EN.
- Defined: adds output ports stall_cnt_o (32) and flush_cnt_o (16).
  - stall_cnt_o increments each cycle out_valid_o=1 & out_ready_i=0.
  - flush_cnt_o increments on each edge with flush_i=1.
  - Both saturate at all-ones (no wrap). Both clear on reset only, not on flush.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
1. Reset deassert, idle -> out_valid_o=0, in_ready_o=1, count_o=0, data_o=FLUSH_VAL (set FLUSH_VAL=32'h00000013).
2. Streaming: in_valid_i=1 with data 1,2,3,4 on consecutive cycles, out_ready_i=1 -> data_o=1,2,3,4 one cycle later each, count_o=1 throughout, in_ready_o=1.
3. Backpressure: send A=0xA, B=0xB with out_ready_i=0 -> count_o=2, in_ready_o=0, data_o=0xA held. Raise out_ready_i for 2 cycles -> data_o 0xA then 0xB, count_o 1 then 0.
4. Flush while FULL with simultaneous in_valid_i=1 (C=0xC) -> next cycle count_o=0, out_valid_o=0, data_o=FLUSH_VAL; C is never output.
5. Async reset asserted mid-cycle while BUSY -> outputs go to reset values before the next clock edge. After release, a new item emerges with 1-cycle latency.
6. (With PIPE_STAGE_PERF_CNT_EN) 5 cycles valid & !ready, then 2 flushes -> stall_cnt_o=5, flush_cnt_o=2. Force stall_cnt_o near max -> it saturates at 32'hFFFFFFFF.
